// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which the
    // unsigned datapath then reads as +2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle on magnitudes,
// followed by one sign-fix cycle; fixed 33-edge latency for every op.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting; accepts start (priority) or mthi/mtlo moves
//   ST_MUL  | 32 shift-add steps on the shared 64-bit accumulator
//   ST_DIV  | 32 restoring shift-subtract steps on the same accumulator
//   ST_FIX  | apply result signs, write HI/LO, pulse done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mthi,
    input  logic            mtlo,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div0_q, div0_d;
    logic                is_div_q, is_div_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    logic                is_signed;
    logic [XLEN-1:0]     rs_abs, rt_abs;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_tmp;
    logic                div_fits;
    logic [XLEN-1:0]     div_sub;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     rem_fix, quo_fix;

    assign is_signed = ~op[0];
    assign rs_abs    = abs32(rs_data, is_signed);
    assign rt_abs    = abs32(rt_data, is_signed);

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting into quotient}.
    // A zero divisor always "fits", giving quotient all-ones and the
    // dividend back as remainder without any special path.
    assign div_tmp  = acc_q[2*XLEN-1:XLEN-1];
    assign div_fits = (div_tmp >= {1'b0, opnd_q});
    assign div_sub  = div_tmp[XLEN-1:0] - opnd_q;
    assign div_next = div_fits ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                               : {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    assign quo_fix  = div0_q    ? {XLEN{1'b1}}
                    : (neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0]);

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = op[1] ? ST_DIV : ST_MUL;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = is_signed & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                    neg_rem_d = is_signed & rs_data[XLEN-1];
                    div0_d    = (rt_data == '0);
                    if (op[1]) begin
                        opnd_d = rt_abs;
                        acc_d  = {{XLEN{1'b0}}, rs_abs};
                    end else begin
                        opnd_d = rs_abs;
                        acc_d  = {{XLEN{1'b0}}, rt_abs};
                    end
                end else begin
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected {HI,LO} per
// operation, monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi, model_lo;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin p = sa * sb; return 64'(p); end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 with hi=0x%0h lo=0x%0h, required no pulse", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
                    check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // Called just after an edge; the next edge is E0. Returns just after E33,
    // so an immediate following call starts back-to-back.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_mthi);
        logic [63:0] e;
        logic [31:0] old_hi, old_lo;
        bit seen;
        e      = ref_model(o, a, b);
        old_hi = model_hi;
        old_lo = model_lo;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mthi    = with_mthi;
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        @(posedge clk); #1;
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        check("busy_after_e0", {63'd0, busy}, 64'd1);
        if (with_mthi) check("start_beats_mthi", {32'd0, hi}, {32'd0, old_hi});
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (disturb && k == 5) begin
                start   = 1'b1;
                mthi    = 1'b1;
                rs_data = 32'h55;
                op      = 2'($urandom);
            end
            @(posedge clk); #1;
            if (disturb && k == 5) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check("done_latency", 64'(k), 64'd33);
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end else if (k == 6 || k == 32) begin
                check("busy_mid", {63'd0, busy}, 64'd1);
                check("hi_stable_mid", {32'd0, hi}, {32'd0, old_hi});
                check("lo_stable_mid", {32'd0, lo}, {32'd0, old_lo});
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done within 40 edges, required done at edge 33");
        end
    endtask

    task automatic do_move(input bit wh, input bit wl, input logic [31:0] v);
        mthi    = wh;
        mtlo    = wl;
        rs_data = v;
        @(posedge clk); #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wh) model_hi = v;
        if (wl) model_lo = v;
        check("move_hi", {32'd0, hi}, {32'd0, model_hi});
        check("move_lo", {32'd0, lo}, {32'd0, model_lo});
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00;
        rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
        model_hi = '0; model_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;

        // Directed cases, run back-to-back.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("divu0_model_hi", {32'd0, hi}, 64'h0);
        run_op(2'b11, 32'd1000, 32'd7, 1'b1, 1'b0);
        check("divu_disturb_hi", {32'd0, hi}, 64'd6);
        check("divu_disturb_lo", {32'd0, lo}, 64'd142);

        // Moves in IDLE, then start with mthi on the same edge.
        do_move(1'b0, 1'b1, 32'h1234);
        do_move(1'b1, 1'b1, 32'hCAFE_F00D);
        run_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b1);

        // Reset in the middle of MULTU 5x5.
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_hi_later", {32'd0, hi}, 64'd0);

        // Randomized operations with occasional moves and divide-by-zero.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = rand_val();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_val();
            if ($urandom_range(0, 3) == 0)
                do_move(1'($urandom), 1'($urandom), $urandom);
            run_op(2'($urandom), a, b, 1'($urandom_range(0, 5) == 0), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("final_hi", {32'd0, hi}, {32'd0, model_hi});
        check("final_lo", {32'd0, lo}, {32'd0, model_lo});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have `clk` input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have `rst` input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have `start` input, 1 bit: request a new operation, sampled on a rising edge.
REQ-005 SHALL have `op` input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have `rs_data` input, 32 bits: register-file read port 1 value (multiplicand / dividend).
REQ-007 SHALL have `rt_data` input, 32 bits: register-file read port 2 value (multiplier / divisor).
REQ-008 SHALL have `mthi` input, 1 bit: write `rs_data` into HI.
REQ-009 SHALL have `mtlo` input, 1 bit: write `rs_data` into LO.
REQ-010 SHALL have `busy` output, 1 bit: an operation is in progress.
REQ-011 SHALL have `done` output, 1 bit: one-cycle pulse when HI/LO take a new result.
REQ-012 SHALL have `hi` output, 32 bits: HI register (product upper half / remainder).
REQ-013 SHALL have `lo` output, 32 bits: LO register (product lower half / quotient).

Function
REQ-014 SHALL implement states IDLE, MUL, DIV and FIX.
REQ-015 SHALL leave IDLE only when `start`=1; `op`[1]=0 goes to MUL, `op`[1]=1 goes to DIV.
REQ-016 SHALL, on the accepting edge E0, latch the operands as absolute values for signed ops (unchanged for unsigned ops), latch the result signs, and clear the iteration counter.
REQ-017 SHALL perform one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle, on edges E1..E32.
REQ-018 SHALL go to FIX after the 32nd step (E32), with the 6-bit counter reaching 32.
REQ-019 SHALL, at edge E33 in FIX: apply the two's-complement sign fix, write HI/LO, return to IDLE, and drive `busy`=0 and `done`=1 for exactly that one following cycle.
REQ-020 SHALL hold `busy`=1 from after E0 through E33, a fixed latency of 33 edges for every op and operand value.
REQ-021 SHALL produce, for MULT/MULTU, the 64-bit product as {HI,LO}; MULT is the signed product.
REQ-022 SHALL produce, for DIV/DIVU, quotient in LO and remainder in HI; signed quotient truncates toward zero, and remainder takes the sign of the dividend.
REQ-023 SHALL, on divide by zero (`rt_data`=0), set HI to the dividend and LO to 0xFFFFFFFF for both DIV and DIVU, with the same 33-edge latency.
REQ-024 SHALL, on DIV of 0x80000000 by 0xFFFFFFFF, set LO=0x80000000 and HI=0 with no error indication.
REQ-025 SHALL ignore `start`, `mthi` and `mtlo` while `busy`=1; HI/LO do not change until E33.
REQ-026 SHALL, in IDLE, write HI (`mthi`) or LO (`mtlo`) from `rs_data` on the next edge; both asserted writes both.
REQ-027 SHALL, in IDLE, give `start` priority over `mthi`/`mtlo` on the same edge; the move is dropped.
REQ-028 SHALL accept a new `start` in the cycle `done`=1; results are back-to-back with no bubble.
REQ-029 SHALL keep `hi`/`lo` stable, as register outputs, at all times other than the update edges.

Reset
REQ-030 SHALL, when `rst`=1 at a rising edge: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, operand registers=0.
REQ-031 SHALL abort any in-progress operation on reset with HI/LO cleared; no partial result is ever written.
REQ-032 SHALL give `rst` priority over `start`, `mthi` and `mtlo` on the same edge.

Structure
REQ-033 SHALL place the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum and the constant ITER=32 in shared package muldiv_pkg, for use by the control decoder.
REQ-034 SHALL NOT split out a sub-module; one datapath with a 64-bit accumulator/remainder register shared by MUL and DIV is natural.
REQ-035 SHALL contain no combinational 32x32 multiplier or divider array.

Verification
REQ-036 SHALL test MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` is high exactly 33 edges after the `start` edge.
REQ-037 SHALL test MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 SHALL test DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 SHALL test DIVU 1000/7 started, a second `start` plus `mthi` with rs=0x55 at cycle 5, then completion -> only HI=6, LO=142 appear, with one `done` pulse.
REQ-040 SHALL test `rst` asserted at cycle 10 of MULTU 5x5 -> next cycle `busy`=0, HI=LO=0, and `done` never pulses.
REQ-041 SHALL test, in IDLE, `mtlo`=1 with rs=0x1234 and `start`=0 -> LO=0x1234 next edge; `start` with `mthi` on the same edge -> HI unchanged.
